nn_layer_sequencer: RTL and testbench
=====================================

// Module: nn_layer_sequencer
// PURPOSE
//  Sequences the shared 15-lane MAC datapath through every network layer on a start/done handshake.
//  Per layer it drives:
//   - weight/result memory row address
//   - accumulator clear and enable
//   - operand-source selects
//   - result write-back strobe
//  Sits between the image-ready source and the feed-forward datapath, replacing a hard-wired layer FSM.
//  Tolerates synchronous weight ROMs via a parameterised read latency.
// PARAMETERS
//  ADR_LEN     9    width of row address / row counter
//  NUM_LAYERS  3    layers processed per inference (1..4)
//  IN_ROWS     257  rows in layer 0 (256 pixels + bias row)
//  HID_ROWS    16   rows in layers 1..NUM_LAYERS-1 (15 nodes + bias row)
//  ROM_LAT     1    weight/operand read latency in cycles (0 or 1)
// PORTS
//  clk        in   1        clock
//  reset      in   1        async active-high reset
//  start      in   1        request one inference; sampled only in IDLE
//  abort      in   1        synchronous cancel of the current inference
//  busy       out  1        high in every state except IDLE
//  done       out  1        one-cycle pulse when the last layer has been written back
//  addr       out  ADR_LEN  row address to weight ROMs, input memory and result RAM
//  acc_clear  out  1        clears all lane accumulators
//  acc_en     out  1        accumulate this cycle's product
//  wb_we      out  1        write activated lane results to result RAM
//  src1_sel   out  1        0 = image operand, 1 = previous-layer result
//  layer      out  2        current layer index; also drives the weight-ROM select
// BEHAVIOUR
//  Reset is asynchronous, active-high; clock is clk.
//   - Reset value: state IDLE, every output 0, layer 0, addr 0, row counter 0.
//  States: IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE.
//  IDLE:
//   - start=1 and abort=0 -> CLEAR with layer=0.
//   - Otherwise stay in IDLE.
//  CLEAR (1 cycle):
//   - acc_clear=1, addr=0.
//   - -> ISSUE.
//  ISSUE (R cycles; R = IN_ROWS when layer 0, else HID_ROWS):
//   - addr steps 0..R-1, one row per cycle.
//   - On the cycle with addr=R-1 -> DRAIN.
//  acc_en:
//   - Equals the ISSUE-valid flag delayed by exactly ROM_LAT cycles.
//   - It is high for exactly R cycles per layer.
//  DRAIN (ROM_LAT cycles; skipped when ROM_LAT=0):
//   - addr holds R-1.
//   - Only the delayed acc_en remains active.
//  WRITE (1 cycle):
//   - wb_we=1; acc_clear=0 and acc_en=0 (accumulators hold).
//   - layer==NUM_LAYERS-1 -> DONE.
//   - Otherwise layer increments and the FSM goes -> CLEAR.
//  DONE (1 cycle):
//   - done=1; -> IDLE.
//   - start is ignored during DONE.
//  Selects:
//   - src1_sel = (layer != 0).
//   - layer changes only on the WRITE->CLEAR edge.
//  Output exclusivity:
//   - acc_clear, wb_we and done are never high together.
//   - acc_clear is never high in the same cycle as acc_en.
//  Latency from the edge sampling start to done high:
//   - L = NUM_LAYERS*(2+ROM_LAT) + IN_ROWS + (NUM_LAYERS-1)*HID_ROWS + 1 cycles.
//   - Defaults give L = 299.
//  start while busy=1: ignored, with no queuing.
//  start held high continuously: a new run begins from the IDLE cycle following DONE.
//  abort=1 in any non-IDLE state:
//   - Next state is IDLE and all outputs drop to 0.
//   - No done pulse, no further wb_we; the delayed-acc_en pipeline is flushed.
//  abort and start together in IDLE: abort wins and the FSM stays in IDLE.
//  Reset mid-run: immediate return to the reset values; a later start runs a full inference.
//  Row counter: never wraps; reaching R-1 always leaves ISSUE.
//  Parameter check: IN_ROWS and HID_ROWS must fit ADR_LEN (elaboration assertion).
// TESTING
//  T1 Defaults, single start pulse:
//   - Counts: acc_en high 257+16+16 cycles, wb_we pulses 3, layer sequence 0,1,2.
//   - Timing: done exactly at cycle 299, busy low the cycle after.
//  T2 Layer boundaries:
//   - addr reaches 256 in layer 0 and 15 in layers 1/2; never 257.
//   - acc_clear precedes each layer by one cycle.
//   - src1_sel=0 only in layer 0.
//  T3 Pulse start at cycle 50 of a run: ignored; done still at cycle 299 with exactly one done pulse.
//  T4 abort in layer 1 at addr=7:
//   - Next cycle: busy=0, acc_en=0, no further wb_we, no done.
//   - A new start then completes normally in 299 cycles.
//  T5 Assert reset at layer 2, addr=3:
//   - All outputs 0 asynchronously.
//   - Release reset, then start: a full run with correct counts.
//  T6 ROM_LAT=0 build:
//   - Done at cycle 296.
//   - acc_en is coincident with ISSUE.
//   - No DRAIN cycle observed.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps the shared MAC datapath through every layer of one inference.
// Outputs are registered alongside the state; acc_en trails the issue phase by ROM_LAT cycles.
module nn_layer_sequencer #(
    parameter int ADR_LEN    = 9,
    parameter int NUM_LAYERS = 3,
    parameter int IN_ROWS    = 257,
    parameter int HID_ROWS   = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [ADR_LEN-1:0] addr,
    output logic               acc_clear,
    output logic               acc_en,
    output logic               wb_we,
    output logic               src1_sel,
    output logic [1:0]         layer
);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE} state_t;

    localparam logic [ADR_LEN-1:0] IN_LAST    = ADR_LEN'(IN_ROWS - 1);
    localparam logic [ADR_LEN-1:0] HID_LAST   = ADR_LEN'(HID_ROWS - 1);
    localparam logic [1:0]         LAST_LAYER = 2'(NUM_LAYERS - 1);

    generate
        if (IN_ROWS > (1 << ADR_LEN) || HID_ROWS > (1 << ADR_LEN) || IN_ROWS < 1 || HID_ROWS < 1 ||
            ROM_LAT < 0 || ROM_LAT > 1 || NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_bad_params
            $error("nn_layer_sequencer: row counts must fit ADR_LEN, ROM_LAT in 0..1, NUM_LAYERS in 1..4");
        end
    endgenerate

    state_t state;
    logic [ADR_LEN-1:0] last;

    assign last = (layer == 2'd0) ? IN_LAST : HID_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            wb_we     <= 1'b0;
            src1_sel  <= 1'b0;
            layer     <= 2'd0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            wb_we     <= 1'b0;
            src1_sel  <= 1'b0;
            layer     <= 2'd0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state     <= CLEAR;
                    busy      <= 1'b1;
                    acc_clear <= 1'b1;
                    addr      <= '0;
                    layer     <= 2'd0;
                    src1_sel  <= 1'b0;
                end
                CLEAR: begin
                    state     <= ISSUE;
                    acc_clear <= 1'b0;
                    acc_en    <= (ROM_LAT == 0);
                end
                ISSUE: begin
                    // With a registered ROM the last row's product lands during DRAIN.
                    acc_en <= (addr != last) || (ROM_LAT != 0);
                    if (addr == last) begin
                        state <= (ROM_LAT != 0) ? DRAIN : WRITE;
                        wb_we <= (ROM_LAT == 0);
                    end else begin
                        addr <= addr + ADR_LEN'(1);
                    end
                end
                DRAIN: begin
                    state  <= WRITE;
                    acc_en <= 1'b0;
                    wb_we  <= 1'b1;
                end
                WRITE: begin
                    wb_we <= 1'b0;
                    if (layer == LAST_LAYER) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= CLEAR;
                        acc_clear <= 1'b1;
                        addr      <= '0;
                        layer     <= layer + 2'd1;
                        src1_sel  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: table of whole-inference scenarios plus hand sequences for idle-side corners.
module tb_nn_layer_sequencer;
    logic clk = 1'b0, reset = 1'b1, go = 1'b0, abort = 1'b0, sel = 1'b0;
    logic start0, start1;
    logic busy0, done0, acc_clear0, acc_en0, wb_we0, src1_sel0;
    logic busy1, done1, acc_clear1, acc_en1, wb_we1, src1_sel1;
    logic [8:0] addr0, addr1;
    logic [1:0] layer0, layer1;
    logic o_busy, o_done, o_acc_clear, o_acc_en, o_wb_we, o_src1_sel;
    logic [8:0] o_addr;
    logic [1:0] o_layer;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign start0 = go & ~sel;
    assign start1 = go & sel;
    assign o_busy      = sel ? busy1 : busy0;
    assign o_done      = sel ? done1 : done0;
    assign o_addr      = sel ? addr1 : addr0;
    assign o_acc_clear = sel ? acc_clear1 : acc_clear0;
    assign o_acc_en    = sel ? acc_en1 : acc_en0;
    assign o_wb_we     = sel ? wb_we1 : wb_we0;
    assign o_src1_sel  = sel ? src1_sel1 : src1_sel0;
    assign o_layer     = sel ? layer1 : layer0;

    nn_layer_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort), .busy(busy0), .done(done0),
        .addr(addr0), .acc_clear(acc_clear0), .acc_en(acc_en0), .wb_we(wb_we0),
        .src1_sel(src1_sel0), .layer(layer0)
    );

    nn_layer_sequencer #(.ROM_LAT(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort), .busy(busy1), .done(done1),
        .addr(addr1), .acc_clear(acc_clear1), .acc_en(acc_en1), .wb_we(wb_we1),
        .src1_sel(src1_sel1), .layer(layer1)
    );

    typedef struct {
        bit lat0;
        int start_at;
        bit do_abort;
        bit do_reset;
        int exp_done_cyc;
        int exp_acc;
        int exp_wb;
        int exp_dn;
        int exp_quiet;
        bit full;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int n = 0, acc = 0, wbn = 0, dn = 0, done_cyc = 0, quiet = 0, viol = 0, nwl = 0;
        int maxa[3];
        int wl[3];
        bit prev_clear = 0, prev_wb = 0, prev_done = 0, prev_busy = 0, ab_pend = 0, hit = 0;
        logic [1:0] prev_layer = 2'd0;
        maxa = '{0, 0, 0};
        wl = '{-1, -1, -1};
        sel = v.lat0;
        prev_layer = o_layer;
        @(posedge clk); #1 go = 1'b1;
        for (int c = 0; c < 310; c++) begin
            @(posedge clk); n++; #1;
            if (n == 1) go = 1'b0;
            if (n == v.start_at) go = 1'b1;
            else if (n == v.start_at + 1) go = 1'b0;
            if (ab_pend) begin
                chk($sformatf("v%0d abort_busy", idx), int'(o_busy), 0);
                chk($sformatf("v%0d abort_acc_en", idx), int'(o_acc_en), 0);
                abort = 1'b0;
                ab_pend = 0;
                prev_layer = o_layer;
            end
            if (prev_done) chk($sformatf("v%0d busy_after_done", idx), int'(o_busy), 0);
            if (o_acc_en) acc++;
            if (o_wb_we) begin
                if (nwl < 3) wl[nwl] = int'(o_layer);
                nwl++;
                wbn++;
            end
            if (o_done) begin
                dn++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (o_busy && !o_acc_clear && !o_acc_en && !o_wb_we && !o_done) quiet++;
            if (o_busy && o_layer < 2'd3 && int'(o_addr) > maxa[o_layer]) maxa[o_layer] = int'(o_addr);
            // Structural invariants, tallied per cycle and checked once per scenario.
            if (o_acc_clear && o_acc_en) viol++;
            if (int'(o_acc_clear) + int'(o_wb_we) + int'(o_done) > 1) viol++;
            if (o_src1_sel != (o_layer != 2'd0)) viol++;
            if (o_busy && int'(o_addr) > ((o_layer == 2'd0) ? 256 : 15)) viol++;
            if (prev_clear && !(o_addr == 9'd0 && !o_acc_clear && o_busy)) viol++;
            if (o_layer != prev_layer && !prev_wb && !(o_acc_clear && !prev_busy)) viol++;
            if (!o_busy && (o_acc_en || o_wb_we || o_acc_clear)) viol++;
            prev_clear = o_acc_clear;
            prev_wb = o_wb_we;
            prev_done = o_done;
            prev_busy = o_busy;
            prev_layer = o_layer;
            if (v.do_abort && !hit && o_busy && o_layer == 2'd1 && o_addr == 9'd7) begin
                abort = 1'b1;
                hit = 1;
                ab_pend = 1;
            end
            if (v.do_reset && !hit && o_busy && o_layer == 2'd2 && o_addr == 9'd3) begin
                hit = 1;
                #1 reset = 1'b1;
                #1 chk($sformatf("v%0d reset_async_zero", idx),
                       int'({o_busy, o_done, o_addr, o_acc_clear, o_acc_en, o_wb_we, o_src1_sel, o_layer}), 0);
                #3 reset = 1'b0;
                prev_layer = 2'd0;
                prev_clear = 0;
                prev_wb = 0;
                prev_busy = 0;
            end
        end
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done_cyc);
        chk($sformatf("v%0d done_pulses", idx), dn, v.exp_dn);
        chk($sformatf("v%0d acc_en_cycles", idx), acc, v.exp_acc);
        chk($sformatf("v%0d wb_we_pulses", idx), wbn, v.exp_wb);
        chk($sformatf("v%0d quiet_busy_cycles", idx), quiet, v.exp_quiet);
        chk($sformatf("v%0d invariant_violations", idx), viol, 0);
        if (v.full) begin
            chk($sformatf("v%0d max_addr_l0", idx), maxa[0], 256);
            chk($sformatf("v%0d max_addr_l1", idx), maxa[1], 15);
            chk($sformatf("v%0d max_addr_l2", idx), maxa[2], 15);
            for (int i = 0; i < 3; i++) chk($sformatf("v%0d wb_layer%0d", idx, i), wl[i], i);
        end
    endtask

    initial begin
        int k;
        tbl[0] = '{0, -1, 0, 0, 299, 289, 3, 1, 3, 1};
        tbl[1] = '{0, 50, 0, 0, 299, 289, 3, 1, 3, 1};
        tbl[2] = '{0, -1, 1, 0, 0, 264, 1, 0, 2, 0};
        tbl[3] = '{0, -1, 0, 0, 299, 289, 3, 1, 3, 1};
        tbl[4] = '{0, -1, 0, 1, 0, 276, 2, 0, 3, 0};
        tbl[5] = '{0, -1, 0, 0, 299, 289, 3, 1, 3, 1};
        tbl[6] = '{1, -1, 0, 0, 296, 289, 3, 1, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_dut0", int'({busy0, done0, addr0, acc_clear0, acc_en0, wb_we0, src1_sel0, layer0}), 0);
        chk("reset_state_dut1", int'({busy1, done1, addr1, acc_clear1, acc_en1, wb_we1, src1_sel1, layer1}), 0);
        reset = 1'b0;

        @(posedge clk); #1 go = 1'b1; abort = 1'b1;
        @(posedge clk); #1 go = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", int'(busy0), 0);
        @(posedge clk); #1;
        chk("start_abort_idle_busy_later", int'(busy0), 0);

        for (int i = 0; i < 7; i++) run(tbl[i], i);

        sel = 1'b0;
        k = 0;
        @(posedge clk); #1 go = 1'b1;
        while (!o_done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("held_start_done_seen", int'(o_done), 1);
        chk("held_start_latency", k, 299);
        @(posedge clk); #1;
        chk("held_start_idle_gap", int'(o_busy), 0);
        @(posedge clk); #1;
        chk("held_start_restart", int'(o_busy && o_acc_clear), 1);
        go = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("held_start_abort", int'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
